bitwise_op_stream: RTL



---
 rtl/bitwise_op_stream.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/bitwise_op_stream.sv
`default_nettype none
// ============================================================================
// Module   : bitwise_op_stream
// Purpose  : Flow-controlled front end for a bitwise operator datapath.
//            Operand pairs and an opcode arrive over a valid/ready handshake.
//            They are captured in stage 1 and evaluated in stage 2. Results
//            are then queued in a small FIFO until the consumer takes them.
//            Illegal opcodes are dropped without using a FIFO slot and set a
//            sticky flag.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            in_valid/in_ready - input handshake
//            a, b, op          - operands and opcode
//                                (0 AND, 1 OR, 2 XOR, 3 NOT A, 4 NOT B)
//            out_valid/ready   - output handshake
//            out_data, out_op  - FIFO head result and the opcode behind it
//            count             - FIFO occupancy
//            bad_op            - sticky illegal-opcode flag
// Revision : 1.0 - initial release
// ============================================================================
module bitwise_op_stream #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic [2:0]                 op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [2:0]                 out_op,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       bad_op
);

  localparam int c_cw = $clog2(DEPTH + 1);
  localparam int c_aw = $clog2(DEPTH);
  localparam logic [c_cw:0] c_depth = (c_cw + 1)'(DEPTH);

  localparam logic [2:0] c_op_and  = 3'd0;
  localparam logic [2:0] c_op_or   = 3'd1;
  localparam logic [2:0] c_op_xor  = 3'd2;
  localparam logic [2:0] c_op_nota = 3'd3;
  localparam logic [2:0] c_op_notb = 3'd4;

  // Stage 1 capture registers
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [2:0]       r_s1_op;

  // Result FIFO state
  logic [WIDTH-1:0] r_mem_data [DEPTH];
  logic [2:0]       r_mem_op   [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_cw-1:0]  r_count;
  logic             r_bad_op;

  logic             w_accept;
  logic             w_legal;
  logic [WIDTH-1:0] w_result;
  logic             w_push;
  logic             w_pop;
  logic [c_cw:0]    w_occupancy;

  // The credit check counts the stage-1 entry as already occupying a slot.
  // Stage 1 therefore always has room to push. A same-cycle pop is
  // deliberately ignored, so in_ready depends only on registered state.
  assign w_occupancy = {1'b0, r_count} + {{c_cw{1'b0}}, r_s1_valid};
  assign in_ready    = (w_occupancy < c_depth);
  assign w_accept    = in_valid & in_ready;

  always_comb begin
    w_result = '0;
    w_legal  = 1'b1;
    case (r_s1_op)
      c_op_and:  w_result = r_s1_a & r_s1_b;
      c_op_or:   w_result = r_s1_a | r_s1_b;
      c_op_xor:  w_result = r_s1_a ^ r_s1_b;
      c_op_nota: w_result = ~r_s1_a;
      c_op_notb: w_result = ~r_s1_b;
      default:   w_legal  = 1'b0;
    endcase
  end

  assign w_push    = r_s1_valid & w_legal;
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid & out_ready;

  // The head is masked while the FIFO is empty. This makes the outputs read
  // zero after reset even though the storage itself is never cleared.
  assign out_data = out_valid ? r_mem_data[r_rd_ptr] : '0;
  assign out_op   = out_valid ? r_mem_op[r_rd_ptr]   : 3'd0;
  assign count    = r_count;
  assign bad_op   = r_bad_op;

  // Stage 1 capture and FIFO control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= 3'd0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_bad_op   <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_a  <= a;
        r_s1_b  <= b;
        r_s1_op <= op;
      end

      if (r_s1_valid && !w_legal) begin
        r_bad_op <= 1'b1;
      end

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_aw'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_aw'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage is not reset. Stale entries are never visible because
  // out_valid gates the head.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_result;
      r_mem_op[r_wr_ptr]   <= r_s1_op;
    end
  end

endmodule
`default_nettype wire
